wbs_mem_bridge: RTL and testbench

- Parametrised Wishbone slave that maps NUM_REGIONS wide SRAM regions into the 32-bit Wishbone space. Successor to the fixed query/leaf/best mapping.
- Splits each MEM_WIDTH-bit word into 32-bit lanes.
- Combines lane writes in a staging buffer and commits one full-word SRAM write.
- Keeps a read-line buffer so upper lanes do not re-access SRAM.
- Sits between the caravel Wishbone bus and the accelerator's SRAM macros; active only in debug mode (wbs_mode=1).

---
 rtl/wbs_mem_bridge_if.sv | 22 ++
 rtl/wbs_mem_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_wbs_mem_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wbs_mem_bridge_if.sv
// Wishbone slave-side bus bundle for wbs_mem_bridge.
// Signal names keep the caravel _i/_o suffixes as seen from the slave.
interface wbs_mem_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wbs_mem_bridge.sv
// Wishbone slave exposing NUM_REGIONS wide SRAM regions as 32-bit lanes.
// Define WBS_BRIDGE_RMW_EN to fill unwritten bytes of a partial word from SRAM before commit.
module wbs_mem_bridge #(
   parameter int          NUM_REGIONS        = 4,
   parameter int          MEM_WIDTH          = 64,
   parameter int          ADDR_W             = 8,
   parameter logic [31:0] REGION_BASE        = 32'h3001_0000,
   parameter int          REGION_STRIDE_LOG2 = 16
) (
   input  logic                             wb_clk_i,
   input  logic                             rst_n,
   wbs_mem_bridge_if.slave                  wbs,
   input  logic                             wbs_mode,
   output logic [NUM_REGIONS-1:0]           mem_csb,
   output logic [NUM_REGIONS-1:0]           mem_web,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic [MEM_WIDTH-1:0]             mem_wdata,
   input  logic [NUM_REGIONS*MEM_WIDTH-1:0] mem_rdata,
   output logic                             err_flag
);
   localparam int LANES = (MEM_WIDTH + 31) / 32;
   localparam int LB    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int RW    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int SW    = LANES * 32;
   localparam int NB    = SW / 8;
   localparam int TW    = RW + ADDR_W;
   localparam int FLD   = 2 + LB + ADDR_W;
   // Offset bits between the word field and the region field must be zero.
   localparam logic [63:0] HI_MASK64 =
      ((64'd1 << REGION_STRIDE_LOG2) - 64'd1) & ~((64'd1 << FLD) - 64'd1);
   localparam logic [31:0] HI_MASK = HI_MASK64[31:0];

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_CAP, S_W_COMMIT, S_ACK, S_RMW_RD, S_RMW_CAP
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_REGIONS-1:0] csb_q, csb_d, web_q, web_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
   logic                   ack_q, ack_d, err_q, err_d;
   logic [31:0]            dat_q, dat_d;
   logic [SW-1:0]          rbuf_q, rbuf_d, stg_q, stg_d;
   logic                   rbuf_vld_q, rbuf_vld_d, stg_vld_q, stg_vld_d;
   logic [TW-1:0]          rtag_q, rtag_d, stag_q, stag_d;
   logic [NB-1:0]          bm_q, bm_d;
   logic [LB-1:0]          rlane_q, rlane_d;
   logic [RW-1:0]          rreg_q, rreg_d;

   logic [31:0]     off, region_full;
   logic [RW-1:0]   region;
   logic [LB-1:0]   lane;
   logic [ADDR_W-1:0] word;
   logic [TW-1:0]   tag;
   logic            req, mapped, last_lane;
   logic [SW-1:0]   rd_ext, stg_m;
   logic [NB-1:0]   bm_m;

   assign off         = wbs.wbs_adr_i - REGION_BASE;
   assign region_full = off >> REGION_STRIDE_LOG2;
   assign region      = region_full[RW-1:0];
   assign lane        = wbs.wbs_adr_i[2 +: LB];
   assign word        = wbs.wbs_adr_i[2+LB +: ADDR_W];
   assign tag         = {region, word};
   assign req         = wbs.wbs_cyc_i & wbs.wbs_stb_i;
   assign last_lane   = (32'(lane) == LANES - 1);
   assign mapped      = (wbs.wbs_adr_i >= REGION_BASE) && (region_full < 32'(NUM_REGIONS)) &&
                        (32'(lane) < LANES) && ((off & HI_MASK) == 32'd0);

   // Bytes never written in this word come from fill (zero, or SRAM data under RMW).
   function automatic logic [MEM_WIDTH-1:0] commit_word(input logic [SW-1:0] stg,
                                                        input logic [NB-1:0] bm,
                                                        input logic [SW-1:0] fill);
      logic [SW-1:0] w;
      for (int i = 0; i < NB; i++) w[i*8 +: 8] = bm[i] ? stg[i*8 +: 8] : fill[i*8 +: 8];
      return w[MEM_WIDTH-1:0];
   endfunction

   always_comb begin
      rd_ext = '0;
      rd_ext[MEM_WIDTH-1:0] = mem_rdata[int'(rreg_q)*MEM_WIDTH +: MEM_WIDTH];
   end

   always_comb begin
      stg_m = (stg_vld_q && stag_q == tag) ? stg_q : '0;
      bm_m  = (stg_vld_q && stag_q == tag) ? bm_q  : '0;
      for (int b = 0; b < 4; b++) begin
         if (wbs.wbs_sel_i[b]) begin
            stg_m[int'(lane)*32 + b*8 +: 8] = wbs.wbs_dat_i[b*8 +: 8];
            bm_m[int'(lane)*4 + b]          = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      csb_d      = '1;
      web_d      = '1;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ack_d      = 1'b0;
      dat_d      = dat_q;
      err_d      = err_q;
      rbuf_d     = rbuf_q;
      rbuf_vld_d = rbuf_vld_q;
      rtag_d     = rtag_q;
      stg_d      = stg_q;
      stg_vld_d  = stg_vld_q;
      stag_d     = stag_q;
      bm_d       = bm_q;
      rlane_d    = rlane_q;
      rreg_d     = rreg_q;
      case (state_q)
         S_IDLE: if (req) begin
            if (!mapped || !wbs_mode) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               dat_d   = '0;
               err_d   = 1'b1;
            end else if (!wbs.wbs_we_i) begin
               // Lane 0 always refetches so software can force a fresh snapshot.
               if (rbuf_vld_q && rtag_q == tag && lane != '0) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  dat_d   = rbuf_q[int'(lane)*32 +: 32];
               end else begin
                  state_d       = S_RD_REQ;
                  csb_d[region] = 1'b0;
                  addr_d        = word;
                  rreg_d        = region;
                  rlane_d       = lane;
               end
            end else begin
               stg_d     = stg_m;
               bm_d      = bm_m;
               stg_vld_d = 1'b1;
               stag_d    = tag;
               addr_d    = word;
               rreg_d    = region;
               if (!last_lane) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
`ifdef WBS_BRIDGE_RMW_EN
               end else if (!(&bm_m)) begin
                  state_d       = S_RMW_RD;
                  csb_d[region] = 1'b0;
`endif
               end else begin
                  state_d       = S_W_COMMIT;
                  csb_d[region] = 1'b0;
                  web_d[region] = 1'b0;
                  wdata_d       = commit_word(stg_m, bm_m, '0);
               end
            end
         end
         S_RD_REQ: state_d = S_RD_CAP;
         S_RD_CAP: begin
            rbuf_d     = rd_ext;
            rbuf_vld_d = 1'b1;
            rtag_d     = {rreg_q, addr_q};
            dat_d      = rd_ext[int'(rlane_q)*32 +: 32];
            state_d    = S_ACK;
            ack_d      = 1'b1;
         end
`ifdef WBS_BRIDGE_RMW_EN
         S_RMW_RD: state_d = S_RMW_CAP;
         S_RMW_CAP: begin
            state_d       = S_W_COMMIT;
            csb_d[rreg_q] = 1'b0;
            web_d[rreg_q] = 1'b0;
            wdata_d       = commit_word(stg_q, bm_q, rd_ext);
         end
`endif
         S_W_COMMIT: begin
            stg_vld_d  = 1'b0;
            rbuf_vld_d = 1'b0;
            state_d    = S_ACK;
            ack_d      = 1'b1;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         csb_q      <= '1;
         web_q      <= '1;
         addr_q     <= '0;
         wdata_q    <= '0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         err_q      <= 1'b0;
         rbuf_q     <= '0;
         rbuf_vld_q <= 1'b0;
         rtag_q     <= '0;
         stg_q      <= '0;
         stg_vld_q  <= 1'b0;
         stag_q     <= '0;
         bm_q       <= '0;
         rlane_q    <= '0;
         rreg_q     <= '0;
      end else begin
         state_q    <= state_d;
         csb_q      <= csb_d;
         web_q      <= web_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         err_q      <= err_d;
         rbuf_q     <= rbuf_d;
         rbuf_vld_q <= rbuf_vld_d;
         rtag_q     <= rtag_d;
         stg_q      <= stg_d;
         stg_vld_q  <= stg_vld_d;
         stag_q     <= stag_d;
         bm_q       <= bm_d;
         rlane_q    <= rlane_d;
         rreg_q     <= rreg_d;
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign mem_csb       = csb_q;
   assign mem_web       = web_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign err_flag      = err_q;
endmodule

// File: tb/tb_wbs_mem_bridge.sv
// Directed bench for wbs_mem_bridge with a behavioural SRAM per region.
// Expectations follow WBS_BRIDGE_RMW_EN when the bench is built with it.
module tb_wbs_mem_bridge;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wbs_mode = 1'b1;
   logic [3:0]   mem_csb, mem_web;
   logic [7:0]   mem_addr;
   logic [63:0]  mem_wdata;
   logic [255:0] mem_rdata;
   logic         err_flag;

   wbs_mem_bridge_if bus();

   wbs_mem_bridge dut (
      .wb_clk_i (clk),
      .rst_n    (rst_n),
      .wbs      (bus),
      .wbs_mode (wbs_mode),
      .mem_csb  (mem_csb),
      .mem_web  (mem_web),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .err_flag (err_flag)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [4][256];
   logic [63:0] dout [4];
   logic        pl_en = 1'b0;
   logic [1:0]  pl_r = '0;
   logic [7:0]  pl_a = '0;
   logic [63:0] pl_d = '0;

   assign mem_rdata = {dout[3], dout[2], dout[1], dout[0]};

   always @(posedge clk) begin
      if (pl_en) mem[pl_r][pl_a] <= pl_d;
      for (int r = 0; r < 4; r++) begin
         if (!mem_csb[r]) begin
            if (!mem_web[r]) mem[r][mem_addr] <= mem_wdata;
            else             dout[r] <= mem[r][mem_addr];
         end
      end
   end

   int          csb_cnt [4];
   int          web_cnt [4];
   int          viol = 0;
   logic [7:0]  last_addr = '0;
   logic [63:0] last_wdata = '0;

   initial for (int r = 0; r < 4; r++) begin csb_cnt[r] = 0; web_cnt[r] = 0; end

   always @(negedge clk) begin
      if ($countones(~mem_csb) > 1 || (~mem_web & mem_csb) != 4'h0) viol++;
      for (int r = 0; r < 4; r++) begin
         if (!mem_csb[r]) csb_cnt[r]++;
         if (!mem_web[r]) begin
            web_cnt[r]++;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
         end
      end
   end

   int nvec = 0;
   int nfail = 0;

   task automatic preload(input logic [1:0] r, input logic [7:0] a, input logic [63:0] d);
      pl_en = 1'b1; pl_r = r; pl_a = a; pl_d = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output int edges);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
      edges = 0;
      do begin @(posedge clk); #1; edges++; end while (!bus.wbs_ack_o && edges < 20);
      rd = bus.wbs_dat_o;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++; if (mem_csb !== 4'hF) begin nfail++; $display("FAIL rst_csb got %h want f", mem_csb); end
      nvec++; if (mem_web !== 4'hF) begin nfail++; $display("FAIL rst_web got %h want f", mem_web); end
      nvec++; if (mem_addr !== 8'h0) begin nfail++; $display("FAIL rst_addr got %h want 0", mem_addr); end
      nvec++; if (mem_wdata !== 64'h0) begin nfail++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
      nvec++; if (bus.wbs_ack_o !== 1'b0) begin nfail++; $display("FAIL rst_ack got %b want 0", bus.wbs_ack_o); end
      nvec++; if (bus.wbs_dat_o !== 32'h0) begin nfail++; $display("FAIL rst_dat got %h want 0", bus.wbs_dat_o); end
      nvec++; if (err_flag !== 1'b0) begin nfail++; $display("FAIL rst_err got %b want 0", err_flag); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_merge();
      logic [31:0] rd;
      int e, c0, w0;
      c0 = csb_cnt[0]; w0 = web_cnt[0];
      xfer(1'b1, 32'h3001_0010, 32'h0123_4567, 4'hF, rd, e);
      nvec++; if (e !== 1) begin nfail++; $display("FAIL wr_lane0_edges got %0d want 1", e); end
      nvec++; if (csb_cnt[0] - c0 !== 0) begin nfail++; $display("FAIL wr_lane0_csb got %0d want 0", csb_cnt[0] - c0); end
      xfer(1'b1, 32'h3001_0014, 32'h000b_cdef, 4'hF, rd, e);
      nvec++; if (e !== 2) begin nfail++; $display("FAIL wr_lane1_edges got %0d want 2", e); end
      nvec++; if (csb_cnt[0] - c0 !== 1) begin nfail++; $display("FAIL wr_commit_csb got %0d want 1", csb_cnt[0] - c0); end
      nvec++; if (web_cnt[0] - w0 !== 1) begin nfail++; $display("FAIL wr_commit_web got %0d want 1", web_cnt[0] - w0); end
      nvec++; if (last_addr !== 8'd2) begin nfail++; $display("FAIL wr_commit_addr got %h want 02", last_addr); end
      nvec++; if (last_wdata !== 64'h000b_cdef_0123_4567) begin nfail++; $display("FAIL wr_commit_data got %h want 000bcdef01234567", last_wdata); end
   endtask

   task automatic test_read_miss_hit();
      logic [31:0] rd;
      int e, c1;
      preload(2'd1, 8'd7, 64'h1100_1010_DEAD_BEEF);
      c1 = csb_cnt[1];
      xfer(1'b0, 32'h3002_0038, 32'h0, 4'h0, rd, e);
      nvec++; if (e !== 3) begin nfail++; $display("FAIL rd_miss_edges got %0d want 3", e); end
      nvec++; if (rd !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL rd_miss_data got %h want deadbeef", rd); end
      nvec++; if (csb_cnt[1] - c1 !== 1) begin nfail++; $display("FAIL rd_miss_csb got %0d want 1", csb_cnt[1] - c1); end
      c1 = csb_cnt[1];
      xfer(1'b0, 32'h3002_003C, 32'h0, 4'h0, rd, e);
      nvec++; if (e !== 1) begin nfail++; $display("FAIL rd_hit_edges got %0d want 1", e); end
      nvec++; if (rd !== 32'h1100_1010) begin nfail++; $display("FAIL rd_hit_data got %h want 11001010", rd); end
      nvec++; if (csb_cnt[1] - c1 !== 0) begin nfail++; $display("FAIL rd_hit_csb got %0d want 0", csb_cnt[1] - c1); end
   endtask

   task automatic test_partial_write();
      logic [31:0] rd;
      int e, w0;
      preload(2'd0, 8'd5, 64'hFFFF_FFFF_FFFF_FFFF);
      w0 = web_cnt[0];
      xfer(1'b1, 32'h3001_0028, 32'hAAAA_5555, 4'b0011, rd, e);
      xfer(1'b1, 32'h3001_002C, 32'h0000_0000, 4'hF, rd, e);
`ifdef WBS_BRIDGE_RMW_EN
      nvec++; if (e !== 4) begin nfail++; $display("FAIL pw_edges got %0d want 4", e); end
      nvec++; if (last_wdata !== 64'h0000_0000_FFFF_5555) begin nfail++; $display("FAIL pw_data got %h want 00000000ffff5555", last_wdata); end
`else
      nvec++; if (e !== 2) begin nfail++; $display("FAIL pw_edges got %0d want 2", e); end
      nvec++; if (last_wdata !== 64'h0000_0000_0000_5555) begin nfail++; $display("FAIL pw_data got %h want 0000000000005555", last_wdata); end
`endif
      nvec++; if (web_cnt[0] - w0 !== 1) begin nfail++; $display("FAIL pw_web got %0d want 1", web_cnt[0] - w0); end
      nvec++; if (last_addr !== 8'd5) begin nfail++; $display("FAIL pw_addr got %h want 05", last_addr); end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      int e, cs;
      cs = csb_cnt[0] + csb_cnt[1] + csb_cnt[2] + csb_cnt[3];
      xfer(1'b0, 32'h3009_0000, 32'h0, 4'h0, rd, e);
      nvec++; if (e !== 1) begin nfail++; $display("FAIL um_edges got %0d want 1", e); end
      nvec++; if (rd !== 32'h0) begin nfail++; $display("FAIL um_data got %h want 0", rd); end
      nvec++; if (err_flag !== 1'b1) begin nfail++; $display("FAIL um_err got %b want 1", err_flag); end
      nvec++; if (csb_cnt[0] + csb_cnt[1] + csb_cnt[2] + csb_cnt[3] - cs !== 0) begin
         nfail++; $display("FAIL um_csb got %0d want 0", csb_cnt[0] + csb_cnt[1] + csb_cnt[2] + csb_cnt[3] - cs); end
      xfer(1'b0, 32'h3002_003C, 32'h0, 4'h0, rd, e);
      nvec++; if (rd !== 32'h1100_1010) begin nfail++; $display("FAIL um_after_data got %h want 11001010", rd); end
      nvec++; if (err_flag !== 1'b1) begin nfail++; $display("FAIL um_sticky got %b want 1", err_flag); end
   endtask

   task automatic test_mode0();
      logic [31:0] rd;
      int e, ws;
      do_reset();
      nvec++; if (err_flag !== 1'b0) begin nfail++; $display("FAIL m0_err_clr got %b want 0", err_flag); end
      wbs_mode = 1'b0;
      ws = web_cnt[0] + web_cnt[1] + web_cnt[2] + web_cnt[3];
      xfer(1'b1, 32'h3003_0004, 32'h1234_5678, 4'hF, rd, e);
      nvec++; if (e !== 1) begin nfail++; $display("FAIL m0_edges got %0d want 1", e); end
      nvec++; if (web_cnt[0] + web_cnt[1] + web_cnt[2] + web_cnt[3] - ws !== 0) begin
         nfail++; $display("FAIL m0_web got %0d want 0", web_cnt[0] + web_cnt[1] + web_cnt[2] + web_cnt[3] - ws); end
      nvec++; if (err_flag !== 1'b1) begin nfail++; $display("FAIL m0_err got %b want 1", err_flag); end
      wbs_mode = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int e, c1;
      // Reset while the read sits in RD_CAP.
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = 32'h3002_0038; bus.wbs_sel_i = 4'h0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0; #1;
      nvec++; if (mem_csb !== 4'hF) begin nfail++; $display("FAIL rm_rd_csb got %h want f", mem_csb); end
      nvec++; if (bus.wbs_ack_o !== 1'b0) begin nfail++; $display("FAIL rm_rd_ack got %b want 0", bus.wbs_ack_o); end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
      c1 = csb_cnt[1];
      xfer(1'b0, 32'h3002_003C, 32'h0, 4'h0, rd, e);
      nvec++; if (e !== 3) begin nfail++; $display("FAIL rm_refetch_edges got %0d want 3", e); end
      nvec++; if (csb_cnt[1] - c1 !== 1) begin nfail++; $display("FAIL rm_refetch_csb got %0d want 1", csb_cnt[1] - c1); end
      nvec++; if (rd !== 32'h1100_1010) begin nfail++; $display("FAIL rm_refetch_data got %h want 11001010", rd); end
      // Reset while a full-word commit is driving the SRAM.
      xfer(1'b1, 32'h3001_0030, 32'h5555_5555, 4'hF, rd, e);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_adr_i = 32'h3001_0034; bus.wbs_dat_i = 32'h6666_6666; bus.wbs_sel_i = 4'hF;
      @(posedge clk); #1;
      nvec++; if (mem_web !== 4'hE) begin nfail++; $display("FAIL rm_commit_web got %h want e", mem_web); end
      rst_n = 1'b0; #1;
      nvec++; if (mem_csb !== 4'hF || mem_web !== 4'hF) begin
         nfail++; $display("FAIL rm_commit_drop got csb=%h web=%h want f f", mem_csb, mem_web); end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
   endtask

   initial begin
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
      test_reset();
      test_write_merge();
      test_read_miss_hit();
      test_partial_write();
      test_unmapped();
      test_mode0();
      test_reset_mid();
      nvec++; if (viol !== 0) begin nfail++; $display("FAIL csb_onehot got %0d violations want 0", viol); end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
